// File: rtl/relu_sched_pkg.sv
// Shared definitions for the ReLU round-robin scheduler: FSM state encoding
// and the ceiling-log2 helper used to size indices and counters.
package relu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) begin
        p = p * 2;
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/relu_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping around. Advancing with no grant rewinds the pointer to channel 0.
module relu_rr_arbiter
  import relu_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int PW = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_gidx;
  logic [PW-1:0]     w_nxt;
  logic [NUM_CH-1:0] w_grant;
  logic              w_found;
  logic              w_hit;
  int                w_idx;

  // Priority search starting at the pointer, first hit wins
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx          = (int'(r_ptr) + k) % NUM_CH;
      w_hit          = req[w_idx] & ~w_found;
      w_grant[w_idx] = w_hit;
      w_gidx         = w_hit ? PW'(w_idx) : w_gidx;
      w_found        = w_found | w_hit;
    end
    w_nxt = (w_gidx == PW'(NUM_CH - 1)) ? '0 : (w_gidx + PW'(1));
  end

  assign grant = w_grant;

  // Pointer moves past the granted channel on a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_found ? w_nxt : '0;
    end
  end

endmodule

// File: rtl/relu_rr_scheduler.sv
// Frame scheduler: round-robin collects FRAME_LEN pixels from each channel,
// applies ReLU with one cycle of latency and pulses done at end of frame.
module relu_rr_scheduler
  import relu_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int FRAME_LEN  = 1024
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [NUM_CH-1:0]                              req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                   req_data,
  output logic [NUM_CH-1:0]                              req_ready,
  output logic [DATA_WIDTH-1:0]                          out,
  output logic [((clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH))-1:0] out_ch,
  output logic                                           valid_out,
  output logic [NUM_CH-1:0]                              ch_done,
  output logic                                           busy,
  output logic                                           done
);

  localparam int OW = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int CW = (clog2(FRAME_LEN + 1) < 1) ? 1 : clog2(FRAME_LEN + 1);

  state_t                  r_state;
  logic [NUM_CH-1:0]       r_ch_done;
  logic [CW-1:0]           r_cnt [NUM_CH];
  logic [DATA_WIDTH-1:0]   r_out;
  logic [OW-1:0]           r_out_ch;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic [NUM_CH-1:0]       w_arb_req;
  logic [NUM_CH-1:0]       w_grant;
  logic [NUM_CH-1:0]       w_fin;
  logic [NUM_CH-1:0]       w_done_nxt;
  logic [OW-1:0]           w_gidx;
  logic [DATA_WIDTH-1:0]   w_pix;
  logic                    w_xfer;
  logic                    w_launch;

  // Only RUN offers requests; finished channels drop out of the eligible set
  always_comb begin
    w_arb_req = (r_state == ST_RUN) ? (req_valid & ~r_ch_done) : '0;
    w_xfer    = |w_grant;
    w_launch  = (r_state == ST_IDLE) & start;
  end

  relu_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (w_arb_req),
    .advance (w_xfer | w_launch),
    .grant   (w_grant)
  );

  // One-hot grant to index, pixel select and last-pixel detection
  always_comb begin
    w_gidx = '0;
    w_pix  = '0;
    w_fin  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_gidx   = w_gidx | (w_grant[i] ? OW'(i) : '0);
      w_pix    = w_pix | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
      w_fin[i] = w_grant[i] & (r_cnt[i] == CW'(FRAME_LEN - 1));
    end
    w_done_nxt = r_ch_done | w_fin;
  end

  // Frame control FSM with per-channel progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ch_done <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_ch_done <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) r_cnt[i] <= r_cnt[i] + CW'(1);
          end
          r_ch_done <= w_done_nxt;
          if (&w_done_nxt) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ReLU result register; out and out_ch hold when nothing transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out    <= '0;
      r_out_ch <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_out    <= w_pix[DATA_WIDTH-1] ? '0 : w_pix;
        r_out_ch <= w_gidx;
      end
    end
  end

  assign req_ready = w_grant;
  assign out       = r_out;
  assign out_ch    = r_out_ch;
  assign valid_out = r_valid;
  assign ch_done   = r_ch_done;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/relu_rr_scheduler.md
RELU_RR_SCHEDULER -- requirements
Module: relu_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the pixel word width (two's complement).
REQ-002 SHALL have parameter NUM_CH, default 4, the number of requesting channels, range 1..16.
REQ-003 SHALL have parameter FRAME_LEN, default 1024, the pixels per channel per frame, minimum 1.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-006 start  in  1  single-cycle pulse that begins a frame.
REQ-007 req_valid  in  NUM_CH  per-channel pixel valid.
REQ-008 req_data  in  NUM_CH*DATA_WIDTH  per-channel pixel; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  out  NUM_CH  one-hot or zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 out  out  DATA_WIDTH  ReLU result.
REQ-011 out_ch  out  clog2(NUM_CH), minimum 1  channel index of the result on out.
REQ-012 valid_out  out  1  out and out_ch are valid this cycle.
REQ-013 ch_done  out  NUM_CH  sticky flag, set when a channel has delivered FRAME_LEN pixels.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  single-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: req_ready=0; start=1 moves to RUN, clears ch_done and all per-channel counters, and sets the round-robin pointer to 0.
REQ-018 start asserted outside IDLE SHALL be ignored.
REQ-019 RUN: the eligible set is req_valid & ~ch_done; the first eligible channel, searching from the pointer upward with wrap, gets req_ready high. req_ready is combinational from req_valid, ch_done and the pointer.
REQ-020 After a transfer on channel g, the pointer SHALL become (g+1) mod NUM_CH; with no transfer it holds.
REQ-021 Each channel SHALL keep a transfer counter of clog2(FRAME_LEN+1) bits. A transfer at count FRAME_LEN-1 sets ch_done[g]; that channel gets no further grants until the next start.
REQ-022 When the transfer completes the last outstanding channel (all ch_done bits high after the update), the FSM SHALL go RUN->DRAIN. DRAIN lasts one cycle, then DONE lasts one cycle, then IDLE.
REQ-023 done SHALL be high exactly while in DONE.
REQ-024 Datapath latency SHALL be 1 cycle.
- On a transfer cycle, the next cycle has valid_out=1 and out_ch=g.
- out=0 if the MSB of the granted pixel is 1; otherwise out equals the pixel unchanged.
REQ-025 On a cycle with no transfer, valid_out=0 the next cycle; out and out_ch hold their values.
REQ-026 No output backpressure: one result per transfer, never dropped or duplicated.
REQ-027 start and req_valid high in the same cycle: no transfer that cycle, because IDLE grants nothing.
REQ-028 NUM_CH=1: channel 0 is granted whenever it is valid and not done; the pointer stays 0.

Reset
REQ-029 On reset low, the block SHALL immediately enter IDLE and clear to 0: out, out_ch, valid_out, ch_done, busy, done, req_ready, counters and pointer.
REQ-030 Reset mid-frame SHALL discard the in-flight result and all progress; the next start begins a clean frame.

Structure
REQ-031 Package relu_sched_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, RUN=1, DRAIN=2, DONE=3) and the clog2 helper function.
REQ-032 Round-robin selection plus the pointer register SHALL live in sub-module relu_rr_arbiter, with ports clk, reset, req, advance, grant.
- req and grant are NUM_CH bits wide; advance is 1 bit.
- The top level holds the FSM, counters and ReLU output register.

Verification (NUM_CH=4, FRAME_LEN=4)
REQ-033 Reset asserted with random inputs -> all outputs 0 and state IDLE; start ignored while reset is low.
REQ-034 start, then all four channels held valid -> grants 0,1,2,3 repeated 4 times (16 transfers).
- valid_out is high for 16 consecutive cycles starting the cycle after the first transfer.
- done is high 2 cycles after the last transfer; busy falls the following cycle.
REQ-035 Channel 0 pixels 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, 0x00000000 -> out 0x0, 0x0, 0x7FFFFFFF, 0x0 with out_ch=0.
REQ-036 Only channel 2 valid -> granted 4 consecutive cycles; then ch_done=4'b0100 and req_ready[2]=0 while still valid; busy stays high.
REQ-037 Only channels 1 and 3 valid, pointer 0 -> grant order 1,3,1,3,1,3,1,3; ch_done=4'b1010 afterwards.
REQ-038 Reset low after 5 transfers, then a new start with all channels valid -> the full 16-transfer frame completes and done pulses once.
